// File: rtl/pipe_rr_injector_if.sv
// Bundle between the clocked requesters, the injector and the async pipeline input.
// master = injector side; slave = requesters plus the first pipeline stage.
interface pipe_rr_injector_if #(
    parameter int NREQ = 4,
    parameter int DW   = 3
);
    logic [NREQ-1:0]    src_valid;
    logic [NREQ*DW-1:0] src_data;
    logic [NREQ-1:0]    src_ready;
    logic               pipe_req;
    logic [DW-1:0]      pipe_data;
    logic               pipe_ack;

    modport master (
        input  src_valid, src_data, pipe_ack,
        output src_ready, pipe_req, pipe_data
    );

    modport slave (
        output src_valid, src_data, pipe_ack,
        input  src_ready, pipe_req, pipe_data
    );
endinterface

// File: rtl/pipe_rr_injector.sv
// Round-robin injector feeding a 4-phase req/ack bundled-data pipeline.
// Optional watchdog: define PIPE_INJ_TIMEOUT_EN.
module pipe_rr_injector #(
    parameter int NREQ        = 4,
    parameter int DW          = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_rr_injector_if.master      bus,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [15:0]             sent_cnt,
    output logic                    timeout_err
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gid_q, gid_d;
    logic                   req_q, req_d;
    logic [DW-1:0]          data_q, data_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [IW-1:0]          pick;
    logic                   found;
    logic                   ack_s;
    logic                   xfer;
    logic [NREQ-1:0]        ready;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pipe_ack};
    assign ack_s  = sync_q[SYNC_STAGES-1];

    // First valid requester at or after ptr, searching cyclically.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.src_valid[wrap(int'(ptr_q) + k)]) begin
                found = 1'b1;
                pick  = wrap(int'(ptr_q) + k);
            end
        end
    end

    assign xfer = (state_q == IDLE) && found && !rst;

    always_comb begin
        ready = '0;
        if (xfer) begin
            ready[pick] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        req_d   = req_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    data_d  = bus.src_data[pick*DW +: DW];
                    gid_d   = pick;
                    ptr_d   = wrap(int'(pick) + 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!ack_s) begin
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_INJ_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        waiting;

    assign waiting = (state_q == REQ_HI) || (state_q == REQ_LO);

    // Restart on every phase change; saturate so a stuck ack cannot wrap.
    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if ((state_d != state_q) &&
            ((state_d == REQ_HI) || (state_d == REQ_LO))) begin
            wd_d = '0;
        end else if (waiting && (wd_q != 16'hFFFF)) begin
            wd_d = wd_q + 16'd1;
        end
        if (waiting && (wd_q == 16'(TIMEOUT_CYC))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy          = (state_q != IDLE);
    assign grant_id      = gid_q;
    assign sent_cnt      = cnt_q;
    assign bus.src_ready = ready;
    assign bus.pipe_req  = req_q;
    assign bus.pipe_data = data_q;
endmodule

// File: tb/tb_pipe_rr_injector.sv
// Bench for pipe_rr_injector: transaction-level reference model plus directed vectors.
// Build with PIPE_INJ_TIMEOUT_EN to also exercise the watchdog.
module tb_pipe_rr_injector;
    localparam int NREQ = 4;
    localparam int DW   = 3;
    localparam int SS   = 2;
    localparam int TO   = 10;
    localparam int IW   = 2;

    localparam int P_FREE = 0;
    localparam int P_DATA = 1;
    localparam int P_REQ  = 2;
    localparam int P_RET  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [IW-1:0] grant_id;
    logic [15:0]   sent_cnt;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    pipe_rr_injector_if #(.NREQ(NREQ), .DW(DW)) bus ();

    pipe_rr_injector #(
        .NREQ(NREQ),
        .DW(DW),
        .SYNC_STAGES(SS),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .grant_id(grant_id),
        .sent_cnt(sent_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pipeline stand-in: ack follows req three cycles later unless forced.
    int         ack_mode  = 0;
    logic       ack_force = 1'b0;
    logic [2:0] reqh      = '0;

    always @(posedge clk) begin
        #2;
        if (rst) reqh = '0;
        else     reqh = {reqh[1:0], bus.pipe_req};
        bus.pipe_ack = (ack_mode != 0) ? ack_force : reqh[2];
    end

    // Reference model: one word in flight, tracked by handshake phase.
    logic          mval = 1'b0;
    int            ph;
    int            mptr;
    logic [DW-1:0] mdata;
    int            mgid;
    logic [15:0]   mcnt;
    logic [SS:0]   hist;
    logic          merr;
    int            age;

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int              g;
        int              nph;
        logic            acks;
        g  = -1;
        er = '0;
        if (mval) begin
            if (!rst && ph == P_FREE) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && bus.src_valid[(mptr + k) % NREQ] === 1'b1)
                        g = (mptr + k) % NREQ;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk("src_ready", 32'(bus.src_ready), 32'(er));
            chk("busy", 32'(busy), 32'(ph != P_FREE));
            chk("pipe_req", 32'(bus.pipe_req), 32'(ph == P_REQ));
            chk("pipe_data", 32'(bus.pipe_data), 32'(mdata));
            chk("grant_id", 32'(grant_id), 32'(mgid));
            chk("sent_cnt", 32'(sent_cnt), 32'(mcnt));
            chk("timeout_err", 32'(timeout_err), 32'(merr));
        end
        hist = {hist[SS-1:0], bus.pipe_ack};
        acks = hist[SS];
        if (rst) begin
            ph    = P_FREE;
            mptr  = 0;
            mdata = '0;
            mgid  = 0;
            mcnt  = '0;
            hist  = '0;
            merr  = 1'b0;
            age   = 0;
            mval  = 1'b1;
        end else if (mval) begin
            nph = ph;
            case (ph)
                P_FREE: if (g >= 0) begin
                    mdata = bus.src_data[g*DW +: DW];
                    mgid  = g;
                    mptr  = (g + 1) % NREQ;
                    nph   = P_DATA;
                end
                P_DATA: if (!acks) nph = P_REQ;
                P_REQ:  if (acks)  nph = P_RET;
                default: if (!acks) begin
                    mcnt = mcnt + 16'd1;
                    nph  = P_FREE;
                end
            endcase
`ifdef PIPE_INJ_TIMEOUT_EN
            if ((ph == P_REQ || ph == P_RET) && age == TO) merr = 1'b1;
            if (nph != ph && (nph == P_REQ || nph == P_RET)) age = 0;
            else if (ph == P_REQ || ph == P_RET) age++;
`endif
            ph = nph;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    int exp_rr[8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    int got[8];

    initial begin
        int   nx;
        int   cyc;
        logic pend;
        rst           = 1'b1;
        bus.src_valid = '0;
        bus.src_data  = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(bus.pipe_req), 32'd0);
        chk("rst_data", 32'(bus.pipe_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(sent_cnt), 32'd0);
        chk("rst_ready", 32'(bus.src_ready), 32'd0);

        // Single word from requester 2
        step();
        bus.src_valid = 4'b0100;
        bus.src_data  = {3'd7, 3'b101, 3'd7, 3'd7};
        @(negedge clk);
        chk("single_ready", 32'(bus.src_ready), 32'h4);
        step();
        bus.src_valid = '0;
        @(negedge clk);
        chk("single_data_t1", 32'(bus.pipe_data), 32'h5);
        chk("single_req_t1", 32'(bus.pipe_req), 32'd0);
        step();
        @(negedge clk);
        chk("single_req_t2", 32'(bus.pipe_req), 32'd1);
        wait_idle(60);
        chk("single_cnt", 32'(sent_cnt), 32'd1);
        chk("single_gid", 32'(grant_id), 32'd2);
        chk("single_hold", 32'(bus.pipe_data), 32'h5);

        // Round robin, all four requesters valid
        step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.src_valid = 4'b1111;
        bus.src_data  = {3'd4, 3'd3, 3'd2, 3'd1};
        nx   = 0;
        cyc  = 0;
        pend = 1'b0;
        while (nx < 8 && cyc < 400) begin
            @(negedge clk);
            if (pend) begin
                got[nx] = int'(bus.pipe_data);
                nx++;
                pend = 1'b0;
            end
            if (|(bus.src_valid & bus.src_ready)) pend = 1'b1;
            cyc++;
            step();
        end
        bus.src_valid = '0;
        chk("rr_words", 32'(nx), 32'd8);
        for (int i = 0; i < 8; i++) chk("rr_seq", 32'(got[i]), 32'(exp_rr[i]));
        wait_idle(60);
        chk("rr_cnt", 32'(sent_cnt), 32'd8);

        // Stale ack held high before the transfer
        step();
        ack_mode  = 1;
        ack_force = 1'b1;
        repeat (4) step();
        bus.src_valid = 4'b0010;
        bus.src_data  = {3'd0, 3'd0, 3'd6, 3'd0};
        @(negedge clk);
        step();
        bus.src_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale_hold_req", 32'(bus.pipe_req), 32'd0);
            chk("stale_hold_busy", 32'(busy), 32'd1);
            step();
        end
        ack_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_rel_low", 32'(bus.pipe_req), 32'd0);
            step();
        end
        @(negedge clk);
        chk("stale_rel_rise", 32'(bus.pipe_req), 32'd1);
        wait_idle(60);
        chk("stale_cnt", 32'(sent_cnt), 32'd9);
        chk("stale_gid", 32'(grant_id), 32'd1);
        chk("stale_data", 32'(bus.pipe_data), 32'd6);

        // Reset while pipe_req is high
        step();
        bus.src_valid = 4'b0001;
        bus.src_data  = {3'd0, 3'd0, 3'd0, 3'd3};
        @(negedge clk);
        step();
        bus.src_valid = '0;
        cyc = 0;
        @(negedge clk);
        while (!bus.pipe_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_req_seen", 32'(bus.pipe_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_req", 32'(bus.pipe_req), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_cnt", 32'(sent_cnt), 32'd0);
        chk("mid_data", 32'(bus.pipe_data), 32'd0);
        step();
        bus.src_valid = 4'b1000;
        bus.src_data  = {3'd5, 3'd0, 3'd0, 3'd0};
        @(negedge clk);
        chk("mid_next_ready", 32'(bus.src_ready), 32'h8);
        step();
        bus.src_valid = '0;
        wait_idle(60);
        chk("mid_next_cnt", 32'(sent_cnt), 32'd1);
        chk("mid_next_gid", 32'(grant_id), 32'd3);

`ifdef PIPE_INJ_TIMEOUT_EN
        // Ack never returns, then arrives late
        step();
        ack_mode      = 1;
        ack_force     = 1'b0;
        bus.src_valid = 4'b0001;
        bus.src_data  = {3'd0, 3'd0, 3'd0, 3'd2};
        @(negedge clk);
        step();
        bus.src_valid = '0;
        repeat (14) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_req", 32'(bus.pipe_req), 32'd1);
        step();
        ack_mode = 0;
        wait_idle(60);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        chk("to_cnt", 32'(sent_cnt), 32'd2);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog");
    end
endmodule
